// File: rtl/fc_scheduler.sv
// -----------------------------------------------------------------------------
// fc_scheduler
//
// Sequences the binary fully-connected layer behind conv2/maxpool. One signed
// feature is accepted per cycle while in RUN; each accept issues a weight-row
// read (w_rd/w_addr), and the returned row is applied one cycle later. Each
// class accumulator adds the feature where its weight bit is 1 and subtracts
// it where the bit is 0. Accumulators saturate, and any saturation is recorded
// in a sticky flag. When all N_IN features have been applied, the class scores
// are presented with a single-cycle valid pulse.
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous, active-high reset
//   start            begin a new image (honoured only in IDLE)
//   feat_valid       feature present on feat_data
//   feat_data        signed feature, FEAT_W bits
//   feat_ready       high only in RUN
//   w_rd             weight read strobe (feat_valid & feat_ready)
//   w_addr           feature index of the current accept
//   w_data           weight row, valid the cycle after w_rd (1 = +1, 0 = -1)
//   fc_result        class c at [c*ACC_W +: ACC_W], signed; held until next start
//   fc_result_valid  one-cycle pulse when results are final
//   sat_flag         sticky: an accumulator clamped during this image
//   busy             state != IDLE
// -----------------------------------------------------------------------------
module fc_scheduler #(
  parameter int N_IN    = 144,
  parameter int N_CLASS = 10,
  parameter int FEAT_W  = 5,
  parameter int ACC_W   = 10,
  parameter int AW      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       feat_valid,
  input  logic [FEAT_W-1:0]          feat_data,
  output logic                       feat_ready,
  output logic                       w_rd,
  output logic [AW-1:0]              w_addr,
  input  logic [N_CLASS-1:0]         w_data,
  output logic [N_CLASS*ACC_W-1:0]   fc_result,
  output logic                       fc_result_valid,
  output logic                       sat_flag,
  output logic                       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // Two guard bits above the accumulator: one for the feature term, one so
  // that the sum of a full-scale accumulator and a full-scale term cannot wrap.
  localparam int SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] ACC_MIN = SUM_W'(-(2 ** (ACC_W - 1)));
  localparam logic [AW-1:0]           LAST_IDX = AW'(N_IN - 1);

  state_t                    state_q, state_d;
  logic [AW-1:0]             cnt_q, cnt_d;
  logic                      pv_q, pv_d;      // pipeline stage holds a feature
  logic signed [ACC_W:0]     pf_q, pf_d;      // feature, sign-extended to ACC_W+1
  logic signed [ACC_W-1:0]   acc_q [N_CLASS];
  logic signed [ACC_W-1:0]   acc_d [N_CLASS];
  logic                      sat_q, sat_d;

  // Handshake outputs are pure decodes of the registered state and counter.
  assign feat_ready      = (state_q == S_RUN);
  assign w_rd            = feat_valid & feat_ready;
  assign w_addr          = cnt_q;
  assign fc_result_valid = (state_q == S_DONE);
  assign sat_flag        = sat_q;
  assign busy            = (state_q != S_IDLE);

  always_comb begin
    fc_result = '0;
    for (int c = 0; c < N_CLASS; c++) begin
      fc_result[c*ACC_W +: ACC_W] = acc_q[c];
    end
  end

  // Next-state, counter, pipeline and accumulate logic.
  always_comb begin
    logic signed [SUM_W-1:0] term;
    logic signed [SUM_W-1:0] sum;

    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    pv_d    = 1'b0;
    pf_d    = pf_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    term    = '0;
    sum     = '0;

    // Accumulate stage: w_data answers the accept from the previous cycle.
    if (pv_q) begin
      for (int c = 0; c < N_CLASS; c++) begin
        term = w_data[c] ? SUM_W'(pf_q) : -SUM_W'(pf_q);
        sum  = SUM_W'(acc_q[c]) + term;
        if (sum > ACC_MAX) begin
          acc_d[c] = ACC_MAX[ACC_W-1:0];
          sat_d    = 1'b1;
        end else if (sum < ACC_MIN) begin
          acc_d[c] = ACC_MIN[ACC_W-1:0];
          sat_d    = 1'b1;
        end else begin
          acc_d[c] = sum[ACC_W-1:0];
        end
      end
    end

    // pv_q is never set in IDLE, so the clear below cannot collide with an
    // accumulate in the same cycle.
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          sat_d   = 1'b0;
          for (int c = 0; c < N_CLASS; c++) begin
            acc_d[c] = '0;
          end
        end
      end
      S_RUN: begin
        if (feat_valid) begin
          pv_d  = 1'b1;
          pf_d  = (ACC_W + 1)'($signed(feat_data));
          cnt_d = cnt_q + AW'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pv_q    <= 1'b0;
      pf_q    <= '0;
      // NOTE: the accumulator array is reset on purpose: it drives fc_result
      // directly, which must read zero out of reset and after an abort.
      for (int c = 0; c < N_CLASS; c++) begin
        acc_q[c] <= '0;
      end
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pv_q    <= pv_d;
      pf_q    <= pf_d;
      for (int c = 0; c < N_CLASS; c++) begin
        acc_q[c] <= acc_d[c];
      end
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_fc_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fc_scheduler
//
// Two instances share clock and reset: u4 (N_IN=4) for the functional, stall,
// restart and abort cases, u40 (N_IN=40) for saturation. Stimulus is driven
// 1 time unit after the rising edge; the monitor samples on the falling edge.
// The driver pushes expected weight addresses and expected image results into
// queues; the monitor pops and compares whenever w_rd or fc_result_valid is
// seen.
// -----------------------------------------------------------------------------
module tb_fc_scheduler;

  localparam int NC = 10;
  localparam int AW = 10;   // accumulator width
  localparam int RW = NC * AW;

  typedef struct {
    int            dut;
    logic [RW-1:0] res;
    logic          sat;
  } exp_t;

  logic clk, rst;
  logic sel;                 // 0 -> u4, 1 -> u40
  logic start_r, feat_valid_r;
  logic [4:0] feat_data;
  logic [9:0] w_data;

  logic start4, fv4, rdy4, w_rd4, v4, sat4, busy4;
  logic [7:0] addr4;
  logic [RW-1:0] res4;
  logic start40, fv40, rdy40, w_rd40, v40, sat40, busy40;
  logic [7:0] addr40;
  logic [RW-1:0] res40;

  assign start4  = start_r & ~sel;
  assign fv4     = feat_valid_r & ~sel;
  assign start40 = start_r & sel;
  assign fv40    = feat_valid_r & sel;

  fc_scheduler #(.N_IN(4), .N_CLASS(10), .FEAT_W(5), .ACC_W(10), .AW(8)) u4 (
    .clk(clk), .rst(rst), .start(start4), .feat_valid(fv4), .feat_data(feat_data),
    .feat_ready(rdy4), .w_rd(w_rd4), .w_addr(addr4), .w_data(w_data),
    .fc_result(res4), .fc_result_valid(v4), .sat_flag(sat4), .busy(busy4));

  fc_scheduler #(.N_IN(40), .N_CLASS(10), .FEAT_W(5), .ACC_W(10), .AW(8)) u40 (
    .clk(clk), .rst(rst), .start(start40), .feat_valid(fv40), .feat_data(feat_data),
    .feat_ready(rdy40), .w_rd(w_rd40), .w_addr(addr40), .w_data(w_data),
    .fc_result(res40), .fc_result_valid(v40), .sat_flag(sat40), .busy(busy40));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc = -100;
  int addr_q[$];
  exp_t exp_q[$];
  int feats[40];
  logic [9:0] rows[40];

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not allowed here (cycle %0d)", name, cyc);
  endtask

  function automatic logic [RW-1:0] pack(input int c0, input int rest);
    logic [RW-1:0] r;
    r = '0;
    for (int c = 0; c < NC; c++) r[c*AW +: AW] = AW'((c == 0) ? c0 : rest);
    return r;
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (w_rd4 || w_rd40) begin
      if (addr_q.size() == 0) flag_fail("unexpected_w_rd");
      else check("w_addr", w_rd40 ? addr40 : addr4, addr_q.pop_front());
      last_acc = cyc;
    end
    if (v4 || v40) begin
      if (exp_q.size() == 0) flag_fail("unexpected_valid");
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("valid_dut", v40 ? 1 : 0, e.dut);
        check("fc_result", v40 ? res40 : res4, e.res);
        check("sat_flag", v40 ? sat40 : sat4, e.sat);
        check("busy_in_done", v40 ? busy40 : busy4, 1);
        check("valid_latency", cyc, last_acc + 2);
      end
    end
  end

  // Start an image on instance s and feed n features, gap idle cycles between.
  // poke_start raises start mid-RUN and across DRAIN/DONE, where it must be ignored.
  task automatic run_image(input logic s, input int n, input int gap, input bit poke_start);
    int idx = 0;
    int g = 0;
    int guard = 0;
    logic [9:0] nw = '0;
    bit fv;
    @(posedge clk); #1;
    sel = s;
    start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    while (idx < n && guard < 2000) begin
      w_data = nw;
      fv = (g == 0);
      feat_valid_r = fv;
      feat_data = 5'(feats[idx]);
      start_r = poke_start && (idx == 2);
      #0;
      if (fv && (s ? rdy40 : rdy4)) begin
        addr_q.push_back(idx);
        nw  = rows[idx];
        idx = idx + 1;
        g   = gap;
      end else if (!fv) begin
        g = g - 1;
      end
      @(posedge clk); #1;
      guard++;
    end
    feat_valid_r = 1'b0;
    w_data = nw;
    start_r = poke_start;
    if (poke_start) begin
      @(posedge clk); #1;   // DONE cycle, start still high
      @(posedge clk); #1;
      start_r = 1'b0;
    end
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      flag_fail("timeout_waiting_valid");
      exp_q.delete();
    end
    w_data = '0;
  endtask

  task automatic load_basic();
    feats[0] = 3;  rows[0] = 10'h3FF;
    feats[1] = -2; rows[1] = 10'h000;
    feats[2] = 5;  rows[2] = 10'h3FF;
    feats[3] = 1;  rows[3] = 10'h001;
  endtask

  task automatic check_zero4(input string tag);
    check({tag, "_fc_result"}, res4, '0);
    check({tag, "_valid"}, v4, 0);
    check({tag, "_sat"}, sat4, 0);
    check({tag, "_busy"}, busy4, 0);
    check({tag, "_ready"}, rdy4, 0);
    check({tag, "_w_rd"}, w_rd4, 0);
    check({tag, "_w_addr"}, addr4, 0);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; start_r = 1'b0; feat_valid_r = 1'b0;
    feat_data = '0; w_data = '0;
    repeat (2) @(posedge clk); #1;
    check_zero4("reset");
    check("reset_busy40", busy40, 0);
    rst = 1'b0;

    // Idle: feat_valid without start must be ignored.
    feat_valid_r = 1'b1;
    feat_data = 5'd7;
    repeat (4) begin
      @(posedge clk); #1;
      check_zero4("idle");
    end
    feat_valid_r = 1'b0;

    // Basic dot product.
    load_basic();
    exp_q.push_back('{0, pack(11, 9), 1'b0});
    run_image(1'b0, 4, 0, 1'b0);
    wait_done();
    check("basic_busy_after", busy4, 0);

    // Stalls of 3 cycles between features.
    exp_q.push_back('{0, pack(11, 9), 1'b0});
    run_image(1'b0, 4, 3, 1'b0);
    wait_done();

    // start raised during RUN and DONE is ignored; results hold afterwards.
    exp_q.push_back('{0, pack(11, 9), 1'b0});
    run_image(1'b0, 4, 0, 1'b1);
    wait_done();
    repeat (3) @(posedge clk); #1;
    check("ignored_start_busy", busy4, 0);
    check("hold_result4", res4, pack(11, 9));

    // Positive saturation.
    for (int i = 0; i < 40; i++) begin feats[i] = 15; rows[i] = 10'h3FF; end
    exp_q.push_back('{1, pack(511, 511), 1'b1});
    run_image(1'b1, 40, 0, 1'b0);
    wait_done();

    // Negative saturation (-16 also exercises -f at full width).
    for (int i = 0; i < 40; i++) feats[i] = -16;
    exp_q.push_back('{1, pack(-512, -512), 1'b1});
    run_image(1'b1, 40, 0, 1'b0);
    wait_done();
    repeat (4) @(posedge clk); #1;
    check("hold_result40", res40, pack(-512, -512));
    check("hold_sat40", sat40, 1);

    // New start clears results and sat_flag on the next cycle.
    @(posedge clk); #1;
    sel = 1'b1; start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    check("restart_clear_res", res40, '0);
    check("restart_clear_sat", sat40, 0);
    check("restart_busy", busy40, 1);
    sel = 1'b0;

    // Reset after two accepts aborts both instances immediately.
    load_basic();
    run_image(1'b0, 2, 0, 1'b0);
    @(posedge clk); #1;
    check("pre_abort_busy", busy4, 1);
    rst = 1'b1;
    #1;
    check_zero4("abort");
    check("abort_busy40", busy40, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    w_data = '0;

    // Full image from scratch after the abort.
    exp_q.push_back('{0, pack(11, 9), 1'b0});
    run_image(1'b0, 4, 0, 1'b0);
    wait_done();

    repeat (3) @(posedge clk); #1;
    check("addr_queue_drained", addr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_scheduler.md
# fc_scheduler

Sequences the binary fully-connected layer that follows conv2/maxpool. It accepts one signed conv2 feature per cycle and issues the matching weight-row read to the FC weight memory. It accumulates ±feature into N_CLASS saturating accumulators, then presents all class scores with a single-cycle valid pulse to the classification stage.

## Interface
- N_IN, 144: features per image (one weight row per feature)
- N_CLASS, 10: output classes (weight row width)
- FEAT_W, 5: signed feature width
- ACC_W, 10: signed accumulator/result width
- AW, 8: weight address width; must satisfy 2^AW ≥ N_IN
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin new image; honoured only in IDLE
- feat_valid  in  1  feature present
- feat_data  in  FEAT_W  signed feature
- feat_ready  out  1  high only in RUN
- w_rd  out  1  weight read strobe, = feat_valid & feat_ready (combinational)
- w_addr  out  AW  feature index of the current accept (combinational from counter)
- w_data  in  N_CLASS  weight row, valid the cycle after w_rd; bit c=1 means +1, bit c=0 means −1
- fc_result  out  N_CLASS*ACC_W  class c at bits [c*ACC_W +: ACC_W], signed
- fc_result_valid  out  1  one-cycle pulse, results final
- sat_flag  out  1  sticky; some accumulator saturated during this image
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: feat_ready=0; feat_valid ignored. start=1 → RUN. On that same edge, clear all accumulators, feature counter cnt, and sat_flag.
- RUN: feat_ready=1. An accept is feat_valid=1 in RUN.
  - On each accept: w_rd=1, w_addr=cnt. Register sign-extended feat_data into the pipeline stage with a valid bit. cnt←cnt+1.
  - Accept with cnt==N_IN−1 → DRAIN.
- DRAIN: one cycle; feat_ready=0; the last accumulate completes → DONE.
- DONE: fc_result_valid=1 for exactly one cycle → IDLE.
- start outside IDLE is ignored, including in DONE.
- Accumulate stage: in the cycle after an accept, for every class c, acc[c] ← sat(acc[c] + (w_data[c] ? f : −f)).
  - f is the feature sign-extended to ACC_W+1 bits; −f is computed at that width, so −16 is legal.
  - sat clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. Any clamp sets sat_flag.
- fc_result is driven directly from the accumulators. It holds its value after DONE until the next start clears it.
- Gaps in feat_valid during RUN stall cnt with no penalty. Back-to-back accepts every cycle are supported.

## Timing
- Reset values: state=IDLE, all accumulators 0, cnt 0, pipeline valid 0, fc_result 0, fc_result_valid 0, sat_flag 0, busy 0, feat_ready 0. w_rd and w_addr are then 0 by construction.
- Reset mid-operation aborts immediately to these values. No partial result is ever flagged valid.
- Accept in cycle T: w_rd/w_addr are asserted in cycle T, w_data is sampled in T+1, and the accumulator is updated at the end of T+1.
- With the last accept in cycle T: state is DRAIN in T+1. State is DONE with fc_result_valid=1 in T+2, and results are final in that same cycle. State is IDLE in T+3.
- Minimum image time with continuous valid: 1 (start) + N_IN + 2 cycles.
- busy=1 from the cycle after start through the DONE cycle inclusive.

## Test plan
- Reset/idle (N_IN=4): drive feat_valid=1 in IDLE with no start → feat_ready=0, w_rd=0, fc_result_valid never asserts, and all outputs stay 0.
- Basic dot product (N_IN=4): features 3, −2, 5, 1 on 4 consecutive cycles; w_data rows 0x3FF, 0x000, 0x3FF, 0x001.
  - Class 0 = 3+2+5+1 = 11; classes 1–9 = 3+2+5−1 = 9.
  - fc_result_valid pulses exactly 2 cycles after the 4th accept.
  - w_addr sequence is 0, 1, 2, 3.
- Stalls (N_IN=4): same data as the basic test with feat_valid low for 3 cycles between each feature → identical results and addresses; pulse 2 cycles after the last accept.
- Saturation (N_IN=40): feature 15 and w_data=0x3FF every cycle → all classes = 511 and sat_flag=1. Repeat with feature −16 → all = −512, sat_flag=1.
- Restart/ignored start (N_IN=4): assert start during RUN and DONE → no effect. After DONE, results hold. A new start zeroes fc_result and sat_flag in the next cycle.
- Reset mid-image (N_IN=4): assert rst after 2 accepts → all outputs 0 immediately. A following full image yields the correct results from scratch.
